// File: rtl/fc1_dense2_pkg.sv
// Shared definitions for the dense-2 argmax classification stage.
package fc1_dense2_pkg;

    localparam int NUM_CLASSES = 30;
    localparam int NUM_PAIRS   = NUM_CLASSES / 2;
    localparam int IDX_W       = $clog2(NUM_CLASSES);
    localparam int SCORE_W     = 32;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

endpackage

// File: rtl/fc1_dense2_max2.sv
// Combinational signed max of two scored candidates; ties resolve to operand a.
module fc1_dense2_max2 #(
    parameter int DWIDTH = fc1_dense2_pkg::SCORE_W,
    parameter int IDX_W  = fc1_dense2_pkg::IDX_W
) (
    input  logic signed [DWIDTH-1:0] a_score,
    input  logic        [IDX_W-1:0]  a_idx,
    input  logic signed [DWIDTH-1:0] b_score,
    input  logic        [IDX_W-1:0]  b_idx,
    output logic signed [DWIDTH-1:0] max_score,
    output logic        [IDX_W-1:0]  max_idx
);

    logic b_wins;

    assign b_wins    = (b_score > a_score);
    assign max_score = b_wins ? b_score : a_score;
    assign max_idx   = b_wins ? b_idx : a_idx;

endmodule

// File: rtl/core_fc1_dense2_argmax.sv
// Pops even/odd class score pairs from two filter FIFOs, tracks the running
// maximum per image and pushes the winning class index to the result FIFO.
module core_fc1_dense2_argmax
    import fc1_dense2_pkg::state_t, fc1_dense2_pkg::ACCUM, fc1_dense2_pkg::EMIT;
#(
    parameter int DWIDTH    = fc1_dense2_pkg::SCORE_W,
    parameter int NUM_PAIRS = fc1_dense2_pkg::NUM_PAIRS,
    parameter int IDX_W     = fc1_dense2_pkg::IDX_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DWIDTH-1:0] ff_rdata0,
    input  logic [DWIDTH-1:0] ff_rdata1,
    input  logic              ff_empty0,
    input  logic              ff_empty1,
    output logic              ff_rdreq,
    output logic [DWIDTH-1:0] ff_wdata,
    output logic              ff_wrreq,
    input  logic              ff_full
);

    localparam int CNT_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(NUM_PAIRS - 1);

    state_t                    state_reg, state_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic signed [DWIDTH-1:0]  best_score_reg, best_score_next;
    logic [IDX_W-1:0]          best_idx_reg, best_idx_next;
    logic [DWIDTH-1:0]         wdata_reg, wdata_next;

    logic [IDX_W-1:0]          even_idx, odd_idx;
    logic signed [DWIDTH-1:0]  local_score, run_score, sel_score;
    logic [IDX_W-1:0]          local_idx, run_idx, sel_idx;
    logic                      first_pair, last_pair;

    assign even_idx = IDX_W'({cnt_reg, 1'b0});
    assign odd_idx  = IDX_W'({cnt_reg, 1'b1});

    fc1_dense2_max2 #(.DWIDTH(DWIDTH), .IDX_W(IDX_W)) u_pair_max (
        .a_score   (ff_rdata0),
        .a_idx     (even_idx),
        .b_score   (ff_rdata1),
        .b_idx     (odd_idx),
        .max_score (local_score),
        .max_idx   (local_idx)
    );

    // Best is operand a so an equal later score never displaces an earlier class.
    fc1_dense2_max2 #(.DWIDTH(DWIDTH), .IDX_W(IDX_W)) u_best_max (
        .a_score   (best_score_reg),
        .a_idx     (best_idx_reg),
        .b_score   (local_score),
        .b_idx     (local_idx),
        .max_score (run_score),
        .max_idx   (run_idx)
    );

    assign first_pair = (cnt_reg == '0);
    assign last_pair  = (cnt_reg == LAST_PAIR);
    assign sel_score  = first_pair ? local_score : run_score;
    assign sel_idx    = first_pair ? local_idx : run_idx;
    assign ff_wdata   = wdata_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= ACCUM;
            cnt_reg        <= '0;
            best_score_reg <= '0;
            best_idx_reg   <= '0;
            wdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            best_score_reg <= best_score_next;
            best_idx_reg   <= best_idx_next;
            wdata_reg      <= wdata_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        best_score_next = best_score_reg;
        best_idx_next   = best_idx_reg;
        wdata_next      = wdata_reg;
        ff_rdreq        = 1'b0;
        ff_wrreq        = 1'b0;

        case (state_reg)
            ACCUM: begin
                if (!reset && !ff_empty0 && !ff_empty1) begin
                    ff_rdreq        = 1'b1;
                    best_score_next = sel_score;
                    best_idx_next   = sel_idx;
                    if (last_pair) begin
                        wdata_next = DWIDTH'(sel_idx);
                        cnt_next   = '0;
                        state_next = EMIT;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            EMIT: begin
                if (!reset && !ff_full) begin
                    ff_wrreq   = 1'b1;
                    state_next = ACCUM;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_core_fc1_dense2_argmax.sv
// Scoreboard bench: stimulus queues expected argmax indices, a monitor checks pushes.
module tb_core_fc1_dense2_argmax;

    localparam int DWIDTH    = 32;
    localparam int NUM_PAIRS = 3;
    localparam int IDX_W     = 3;

    typedef logic signed [DWIDTH-1:0] score_t;
    typedef score_t pair_arr_t [NUM_PAIRS];

    logic              clock = 1'b0;
    logic              reset;
    logic [DWIDTH-1:0] ff_rdata0, ff_rdata1;
    logic              ff_empty0, ff_empty1;
    logic              ff_rdreq;
    logic [DWIDTH-1:0] ff_wdata;
    logic              ff_wrreq;
    logic              ff_full;

    core_fc1_dense2_argmax #(
        .DWIDTH    (DWIDTH),
        .NUM_PAIRS (NUM_PAIRS),
        .IDX_W     (IDX_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ff_rdata0 (ff_rdata0),
        .ff_rdata1 (ff_rdata1),
        .ff_empty0 (ff_empty0),
        .ff_empty1 (ff_empty1),
        .ff_rdreq  (ff_rdreq),
        .ff_wdata  (ff_wdata),
        .ff_wrreq  (ff_wrreq),
        .ff_full   (ff_full)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    score_t q0[$];
    score_t q1[$];
    int     expq[$];
    int     push_cycles[$];
    bit     stall0, stall1, full_flag, rst_flag, rand_mode;
    int     pops_in_image, first_pop_cycle, total_pops;
    int     compared = 0;
    int     mismatched = 0;

    // Reference: argmax over the flat class list, first occurrence of the maximum wins.
    function automatic int ref_argmax(pair_arr_t s0, pair_arr_t s1);
        score_t cls [2*NUM_PAIRS];
        int best = 0;
        for (int k = 0; k < NUM_PAIRS; k++) begin
            cls[2*k]   = s0[k];
            cls[2*k+1] = s1[k];
        end
        for (int i = 1; i < 2*NUM_PAIRS; i++)
            if (cls[i] > cls[best]) best = i;
        return best;
    endfunction

    task automatic check(string name, longint actual, longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic send_image(pair_arr_t s0, pair_arr_t s1);
        for (int k = 0; k < NUM_PAIRS; k++) begin
            q0.push_back(s0[k]);
            q1.push_back(s1[k]);
        end
        expq.push_back(ref_argmax(s0, s1));
        $display("image queued: expected class %0d", expq[$]);
    endtask

    // One clock cycle of the show-ahead FIFO models and control inputs.
    task automatic tick();
        @(negedge clock);
        if (rand_mode) begin
            stall0    = ($urandom_range(0, 4) == 0);
            stall1    = ($urandom_range(0, 4) == 0);
            full_flag = ($urandom_range(0, 3) == 0);
        end
        reset     = rst_flag;
        ff_full   = full_flag;
        ff_empty0 = (q0.size() == 0) || stall0;
        ff_empty1 = (q1.size() == 0) || stall1;
        ff_rdata0 = (q0.size() != 0) ? q0[0] : score_t'($urandom);
        ff_rdata1 = (q1.size() != 0) ? q1[0] : score_t'($urandom);
        #1;
        if (ff_rdreq) begin
            if (q0.size() != 0) void'(q0.pop_front());
            if (q1.size() != 0) void'(q1.pop_front());
            if (pops_in_image == 0) first_pop_cycle = cyc;
            pops_in_image = (pops_in_image + 1) % NUM_PAIRS;
            total_pops++;
        end
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((expq.size() != 0 || q0.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_pending_results", expq.size(), 0);
    endtask

    // Monitor: invariants every cycle, result compare on every push.
    always @(negedge clock) begin
        #2;
        if (reset) begin
            check("reset_rdreq", ff_rdreq, 0);
            check("reset_wrreq", ff_wrreq, 0);
        end else begin
            check("pop_while_empty", ff_rdreq && (ff_empty0 || ff_empty1), 0);
            check("push_while_full", ff_wrreq && ff_full, 0);
            check("pop_push_overlap", ff_rdreq && ff_wrreq, 0);
            if (ff_wrreq) begin
                push_cycles.push_back(cyc);
                if (expq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_push: ff_wdata=%0d, no result expected", ff_wdata);
                end else begin
                    $display("push: ff_wdata=%0d expected=%0d cycle=%0d", ff_wdata, expq[0], cyc);
                    check("result_index", ff_wdata, expq.pop_front());
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pair_arr_t a, b;
        int n, start, v;

        rst_flag = 1; reset = 1; full_flag = 0; stall0 = 0; stall1 = 0; rand_mode = 0;
        ff_full = 0; ff_empty0 = 1; ff_empty1 = 1; ff_rdata0 = '0; ff_rdata1 = '0;
        pops_in_image = 0; first_pop_cycle = 0; total_pops = 0;

        // Basic image, queued during reset so pops are visibly suppressed.
        a = '{5, 7, 1}; b = '{2, 9, 3};
        send_image(a, b);
        repeat (3) tick();
        check("reset_wdata", ff_wdata, 0);
        check("reset_no_pops", total_pops, 0);
        rst_flag = 0;
        drain(50);
        check("first_pop_to_push", push_cycles[$] - first_pop_cycle, NUM_PAIRS);
        push_cycles.delete();

        // Back-to-back directed images: negatives, intra-pair tie, last odd slot.
        a = '{-10, -8, -4}; b = '{-4, -20, -30}; send_image(a, b);
        a = '{6, 0, 0};     b = '{6, 0, 0};      send_image(a, b);
        a = '{0, 0, 1};     b = '{0, 0, 2};      send_image(a, b);
        drain(100);
        check("b2b_push_count", push_cycles.size(), 3);
        for (int i = 1; i < push_cycles.size(); i++)
            check("b2b_push_spacing", push_cycles[i] - push_cycles[i-1], NUM_PAIRS + 1);

        // Empty stall on filter1 after two pairs.
        a = '{5, 7, 1}; b = '{2, 9, 3};
        send_image(a, b);
        n = 0;
        while (pops_in_image != 2 && n < 20) begin tick(); n++; end
        check("stall_reached_pair2", pops_in_image, 2);
        stall1 = 1;
        start = total_pops;
        repeat (5) begin
            tick();
            check("stall_rdreq", ff_rdreq, 0);
        end
        check("stall_no_pops", total_pops - start, 0);
        stall1 = 0;
        drain(50);

        // Result FIFO full on entering EMIT, with next image already available.
        full_flag = 1;
        a = '{3, -1, 8}; b = '{4, 2, -5};
        send_image(a, b);
        start = total_pops;
        n = 0;
        while (total_pops - start < NUM_PAIRS && n < 20) begin tick(); n++; end
        check("full_pairs_popped", total_pops - start, NUM_PAIRS);
        a = '{1, 1, 1}; b = '{1, 1, 1};
        send_image(a, b);
        repeat (4) begin
            tick();
            check("full_wrreq", ff_wrreq, 0);
            check("full_rdreq", ff_rdreq, 0);
            check("full_wdata_stable", ff_wdata, expq[0]);
        end
        full_flag = 0;
        tick();
        check("full_release_push", ff_wrreq, 1);
        drain(50);

        // Reset pulse in the middle of the second image.
        a = '{11, -3, 4}; b = '{2, 12, 12};
        send_image(a, b);
        start = total_pops;
        for (int k = 0; k < NUM_PAIRS; k++) begin
            q0.push_back(score_t'(1000 + k));
            q1.push_back(score_t'(2000 + k));
        end
        n = 0;
        while (total_pops - start < NUM_PAIRS + 2 && n < 50) begin tick(); n++; end
        check("mid_image_pops", total_pops - start, NUM_PAIRS + 2);
        rst_flag = 1;
        q0.delete(); q1.delete();
        pops_in_image = 0;
        repeat (2) tick();
        check("mid_reset_wdata", ff_wdata, 0);
        rst_flag = 0;
        a = '{-7, 20, 3}; b = '{-9, 19, 21};
        send_image(a, b);
        drain(50);

        // Randomized images with random stalls and result back-pressure.
        rand_mode = 1;
        for (int img = 0; img < 25; img++) begin
            for (int k = 0; k < NUM_PAIRS; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    a[k] = score_t'($urandom);
                    b[k] = score_t'($urandom);
                end else begin
                    v = int'($urandom_range(0, 6)) - 3; a[k] = score_t'(v);
                    v = int'($urandom_range(0, 6)) - 3; b[k] = score_t'(v);
                end
            end
            send_image(a, b);
        end
        drain(3000);
        rand_mode = 0; stall0 = 0; stall1 = 0; full_flag = 0;
        repeat (3) tick();
        check("final_fifos_drained", q0.size() + q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
